// File: rtl/l2_arbiter_pkg.sv
// Shared types for the two-port L2 arbiter: FSM state encoding, port ids and a port helper.
// Winner selection mode is chosen in l2_arb_pick by the L2_ARB_ROUND_ROBIN_EN macro.
package l2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Word-address memory request bundle used for both requester ports and the L2 side.
// The master drives address/data/write-enable/start; the slave returns q and a done pulse.
interface l2_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              start;
  logic [DATA_W-1:0] q;
  logic              done;

  modport master (output addr, output data, output we, output start, input q, input done);
  modport slave  (input addr, input data, input we, input start, output q, output done);
endinterface

// File: rtl/l2_arb_pick.sv
// Combinational winner select between the fetch port (0) and the data port (1).
// Define L2_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port wins every tie.
module l2_arb_pick
  import l2_arbiter_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       win
);

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Tie goes to whichever port was not granted last.
  always_comb begin
    if (elig == 2'b11) begin
      win = other_port(last_grant);
    end else if (elig[1]) begin
      win = PORT_MEM;
    end else begin
      win = PORT_IF;
    end
  end
`else
  logic [1:0] unused_pick;
  assign unused_pick = {last_grant, elig[0]};

  always_comb begin
    if (elig[1]) begin
      win = PORT_MEM;
    end else begin
      win = PORT_IF;
    end
  end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 CPU bus between instruction fetch (p0) and data memory (p1): latches the
// winner, holds it stable at the L2 and routes q/done back to the owner. See L2_ARB_ROUND_ROBIN_EN.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  l2_arbiter_if.slave   p0,
  l2_arbiter_if.slave   p1,
  l2_arbiter_if.master  l2,
  output logic          grant,
  output logic          busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              l2_start_q, l2_start_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              abandon_q, abandon_d;
  logic              busy_q, busy_d;
  logic [1:0]        served_q, served_d;

  logic [1:0]        elig_s;
  logic [1:0]        done_s;
  logic              win_s;
  logic              owner_start_s;
  logic              in_wait_s;

  // A port whose done already fired stays ineligible until it lowers start.
  assign elig_s        = {p1.start & ~served_q[1], p0.start & ~served_q[0]};
  assign owner_start_s = (grant_q == PORT_MEM) ? p1.start : p0.start;
  assign in_wait_s     = (state_q == ST_WAIT);
  assign done_s[0]     = l2.done & in_wait_s & (grant_q == PORT_IF)  & ~abandon_q;
  assign done_s[1]     = l2.done & in_wait_s & (grant_q == PORT_MEM) & ~abandon_q;

  l2_arb_pick u_pick (
    .elig       (elig_s),
    .last_grant (last_grant_q),
    .win        (win_s)
  );

  // Transaction FSM: latch winner, raise start, wait for done, then force one low cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    l2_start_d   = l2_start_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    abandon_d    = abandon_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          state_d      = ST_ISSUE;
          grant_d      = win_s;
          last_grant_d = win_s;
          addr_d       = (win_s == PORT_MEM) ? p1.addr : p0.addr;
          data_d       = (win_s == PORT_MEM) ? p1.data : p0.data;
          we_d         = (win_s == PORT_MEM) ? p1.we   : p0.we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        l2_start_d = 1'b1;
        abandon_d  = abandon_q | ~owner_start_s;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        abandon_d = abandon_q | ~owner_start_s;
        if (l2.done) begin
          l2_start_d = 1'b0;
          state_d    = ST_GAP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        abandon_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        l2_start_d = 1'b0;
        abandon_d  = 1'b0;
      end
    endcase
  end

  // Served flags and busy follow the next state so both are plain flops.
  always_comb begin
    served_d[0] = p0.start ? (served_q[0] | done_s[0]) : 1'b0;
    served_d[1] = p1.start ? (served_q[1] | done_s[1]) : 1'b0;
    busy_d      = (state_d != ST_IDLE);
  end

  // State and latched bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      we_q         <= 1'b0;
      l2_start_q   <= 1'b0;
      grant_q      <= PORT_IF;
      last_grant_q <= PORT_MEM;
      abandon_q    <= 1'b0;
      busy_q       <= 1'b0;
      served_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      l2_start_q   <= l2_start_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      abandon_q    <= abandon_d;
      busy_q       <= busy_d;
      served_q     <= served_d;
    end
  end

  assign l2.addr  = addr_q;
  assign l2.data  = data_q;
  assign l2.we    = we_q;
  assign l2.start = l2_start_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign p0.done  = done_s[0];
  assign p1.done  = done_s[1];
  assign p0.q     = (in_wait_s && grant_q == PORT_IF)  ? l2.q : {DATA_W{1'b0}};
  assign p1.q     = (in_wait_s && grant_q == PORT_MEM) ? l2.q : {DATA_W{1'b0}};

endmodule
